// File: rtl/pri_enc_64b.sv
// 64-to-6 priority encoder, two pipeline levels: eight 8-bit group encoders, then a group select.
// An init_i/done_o strobe travels alongside the data; data_o/zero_o hold the last result between strobes.
module pri_enc_64b #(
    parameter logic OUT_REG      = 1'b1,
    parameter logic PRIORITY_MSB = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_i,
    input  logic [63:0] data_i,
    output logic        done_o,
    output logic        zero_o,
    output logic [5:0]  data_o
);

    logic       s1_valid;
    logic       s1_loaded;
    logic [7:0] grp_any;
    logic [2:0] grp_idx [8];

    logic [2:0] sel;
    logic       none_set;
    logic       s2_zero;
    logic [5:0] s2_data;

    // The last set bit visited wins, so the scan direction decides the priority.
    function automatic logic [2:0] pick8(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        if (PRIORITY_MSB) begin
            for (int i = 0; i < 8; i++) begin
                if (vec[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (vec[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid  <= 1'b0;
            s1_loaded <= 1'b0;
            grp_any   <= 8'd0;
            for (int g = 0; g < 8; g++) begin
                grp_idx[g] <= 3'd0;
            end
        end else begin
            s1_valid <= init_i;
            if (init_i) begin
                s1_loaded <= 1'b1;
                for (int g = 0; g < 8; g++) begin
                    grp_any[g] <= |data_i[8*g +: 8];
                    grp_idx[g] <= pick8(data_i[8*g +: 8]);
                end
            end
        end
    end

    // s1_loaded keeps zero_o low after reset until a real sample has been encoded.
    always_comb begin
        sel      = pick8(grp_any);
        none_set = ~|grp_any;
        s2_zero  = s1_loaded & none_set;
        s2_data  = none_set ? 6'd0 : {sel, grp_idx[sel]};
    end

    if (OUT_REG) begin : g_out_reg
        logic       done_r;
        logic       zero_r;
        logic [5:0] data_r;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                done_r <= 1'b0;
                zero_r <= 1'b0;
                data_r <= 6'd0;
            end else begin
                done_r <= s1_valid;
                if (s1_valid) begin
                    zero_r <= s2_zero;
                    data_r <= s2_data;
                end
            end
        end

        assign done_o = done_r;
        assign zero_o = zero_r;
        assign data_o = data_r;
    end else begin : g_comb_out
        assign done_o = s1_valid;
        assign zero_o = s2_zero;
        assign data_o = s2_data;
    end

endmodule
